// File: rtl/sequential_bcd_converter.sv
// Shift-per-clock double-dabble binary-to-BCD converter with a start/done handshake.
// The result registers only change on the done edge, so the display path always sees a coherent value.
//
// state   | meaning
// IDLE    | waiting for start; bcd holds the last result
// CONVERT | one adjust-and-shift per clock, IN_WIDTH clocks in total
module sequential_bcd_converter #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   binary,
    input  logic                  negative,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_negative
);

    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic [IN_WIDTH-1:0]   binSr;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   shifted;
    logic [CW-1:0]         cnt;
    logic                  negQ;

    // Every digit >= 5 gets +3 before the shift; max 12 fits in 4 bits, so no inter-digit carry.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {adjusted[4*DIGITS-2:0], binSr[IN_WIDTH-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = CONVERT;
            CONVERT: if (cnt == LAST) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state == CONVERT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            binSr        <= '0;
            scratch      <= '0;
            cnt          <= '0;
            negQ         <= 1'b0;
            done         <= 1'b0;
            bcd          <= '0;
            bcd_negative <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    binSr   <= binary;
                    scratch <= '0;
                    cnt     <= '0;
                    negQ    <= negative;
                end
            end else begin
                scratch <= shifted;
                binSr   <= {binSr[IN_WIDTH-2:0], 1'b0};
                cnt     <= cnt + 1'b1;
                if (cnt == LAST) begin
                    bcd          <= shifted;
                    bcd_negative <= negQ;
                    done         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sequential_bcd_converter.sv
// Directed-vector bench for sequential_bcd_converter: latency, handshake, hold, abort and back-to-back behaviour.
module tb_sequential_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] binary = '0;
    logic        negative = 1'b0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        bcd_negative;

    int vectors = 0;
    int miscompares = 0;
    logic [19:0] prevBcd = '0;

    sequential_bcd_converter #(.IN_WIDTH(16), .DIGITS(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .binary(binary),
        .negative(negative),
        .busy(busy),
        .done(done),
        .bcd(bcd),
        .bcd_negative(bcd_negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Inputs are scrambled after the accepting edge so only the captured values can produce the result.
    task automatic run(input string tag, input logic [15:0] b, input logic n,
                       input logic [19:0] expBcd, input logic expNeg, input int pulseAt);
        int busyCnt = 0;
        int doneCnt = 0;
        int doneIdx = -1;
        @(negedge clk);
        start = 1'b1; binary = b; negative = n;
        @(posedge clk);
        #1 start = 1'b0; binary = ~b; negative = ~n;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, "_hold"}, 32'(bcd), 32'(prevBcd));
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                doneIdx = i;
            end
            if (i == pulseAt) begin
                start = 1'b1;
                binary = 16'd999;
            end
            if (i == pulseAt + 1) start = 1'b0;
        end
        chk({tag, "_bcd"}, 32'(bcd), 32'(expBcd));
        chk({tag, "_neg"}, 32'(bcd_negative), 32'(expNeg));
        chk({tag, "_busycycles"}, 32'(busyCnt), 32'd16);
        chk({tag, "_donecount"}, 32'(doneCnt), 32'd1);
        chk({tag, "_doneidx"}, 32'(doneIdx), 32'd16);
        prevBcd = expBcd;
    endtask

    initial begin
        int doneCnt;
        int lastDone;
        int pulses;

        // Reset held with start asserted: reset must win.
        start = 1'b1;
        binary = 16'd1234;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_neg", 32'(bcd_negative), 32'd0);
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run("zero",   16'd0,     1'b0, 20'h00000, 1'b0, -10);
        run("sq127",  16'd16129, 1'b1, 20'h16129, 1'b1, -10);
        run("max",    16'd65535, 1'b0, 20'h65535, 1'b0, -10);
        run("m128sq", 16'd16384, 1'b0, 20'h16384, 1'b0, -10);
        run("ignore", 16'h3039,  1'b0, 20'h12345, 1'b0, 5);
        repeat (5) @(negedge clk);
        chk("ignore_quiet_bcd", 32'(bcd), 32'h12345);
        chk("ignore_quiet_busy", 32'(busy), 32'd0);

        run("nine", 16'd9999, 1'b1, 20'h09999, 1'b1, -10);

        // Abort mid-conversion: no done, bcd back to zero.
        @(negedge clk);
        start = 1'b1; binary = 16'd12345; negative = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        chk("abort_nodone", 32'(doneCnt), 32'd0);
        chk("abort_bcd_after", 32'(bcd), 32'd0);
        prevBcd = 20'h00000;
        run("after42", 16'd42, 1'b0, 20'h00042, 1'b0, -10);

        // Start held high: one done every 17 clocks.
        @(negedge clk);
        start = 1'b1; binary = 16'd100; negative = 1'b0;
        @(posedge clk);
        lastDone = -1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b_bcd", 32'(bcd), 32'h00100);
                if (lastDone < 0) chk("b2b_first", 32'(i), 32'd16);
                else chk("b2b_gap", 32'(i - lastDone), 32'd17);
                lastDone = i;
                pulses++;
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd3);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("b2b_drain_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
